// File: rtl/adder_sched_pkg.sv
// Shared widths and types for the round-robin adder scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package adder_sched_pkg;

    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 32;
    localparam int ID_W    = $clog2(NUM_REQ);

    typedef logic [ID_W-1:0]   req_id_t;
    typedef logic [DATA_W-1:0] data_t;

endpackage

// File: rtl/fh_without_carry_adder_32_bits.sv
// Purely combinational 32-bit adder; carry-out is discarded (wraps mod 2^32).
// Latency: 0 cycles.
// Backpressure: none, operands flow straight through.
module fh_without_carry_adder_32_bits
    import adder_sched_pkg::*;
(
    input  data_t i_a,
    input  data_t i_b,
    output data_t o_sum
);

    // Sum truncated to operand width; the overflow bit is intentionally dropped.
    assign o_sum = i_a + i_b;

endmodule

// File: rtl/adder_rr_scheduler.sv
// Round-robin arbiter sharing one adder among NUM_REQ requesters; result held in a one-entry slot.
// Latency: 1 cycle from request transfer to res_valid; one op per cycle while res_ready stays high.
// Backpressure: a held result (res_valid & !res_ready) blocks all grants; enable=0 blocks grants but lets the slot drain.
module adder_rr_scheduler #(
    parameter  int NUM_REQ = adder_sched_pkg::NUM_REQ,
    parameter  int DATA_W  = adder_sched_pkg::DATA_W,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      enable,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_a,
    input  logic [NUM_REQ*DATA_W-1:0] req_b,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      res_valid,
    input  logic                      res_ready,
    output logic [DATA_W-1:0]         res_data,
    output logic [ID_W-1:0]           res_id,
    output logic [15:0]               op_count,
    output logic                      idle
);

    logic [ID_W-1:0]    r_rr_ptr;
    logic               r_res_valid;
    logic [DATA_W-1:0]  r_res_data;
    logic [ID_W-1:0]    r_res_id;
    logic [15:0]        r_op_count;

    logic               w_slot_free;
    logic               w_res_hs;
    logic               w_grant_found;
    logic [ID_W-1:0]    w_grant_idx;
    logic               w_grant;
    logic [ID_W-1:0]    w_ptr_next;
    logic [NUM_REQ-1:0] w_onehot;
    logic [DATA_W-1:0]  w_op_a;
    logic [DATA_W-1:0]  w_op_b;
    logic [DATA_W-1:0]  w_sum;

    // The slot can take a new result if it is empty or being emptied this cycle.
    assign w_res_hs    = r_res_valid & res_ready;
    assign w_slot_free = ~r_res_valid | res_ready;

    // Search for the first valid requester starting at the round-robin pointer, wrapping around.
    always_comb begin
        w_grant_found = 1'b0;
        w_grant_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!w_grant_found && req_valid[(int'(r_rr_ptr) + k) % NUM_REQ]) begin
                w_grant_found = 1'b1;
                w_grant_idx   = ID_W'((int'(r_rr_ptr) + k) % NUM_REQ);
            end
        end
    end

    // Reset gates the grant so nothing transfers into a slot that is being cleared.
    assign w_grant    = enable & w_slot_free & w_grant_found & ~rst;
    assign w_ptr_next = (w_grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : w_grant_idx + 1'b1;
    assign w_onehot   = {{(NUM_REQ-1){1'b0}}, 1'b1} << w_grant_idx;
    assign req_ready  = w_grant ? w_onehot : '0;

    // Grant-indexed operand mux feeding the single shared adder.
    assign w_op_a = req_a[w_grant_idx*DATA_W +: DATA_W];
    assign w_op_b = req_b[w_grant_idx*DATA_W +: DATA_W];

    fh_without_carry_adder_32_bits u_adder (
        .i_a   (w_op_a),
        .i_b   (w_op_b),
        .o_sum (w_sum)
    );

    // Result slot and pointer: a new grant overwrites (or refills) the slot, a bare handshake empties it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
            r_res_id    <= '0;
            r_rr_ptr    <= '0;
        end else if (w_grant) begin
            r_res_valid <= 1'b1;
            r_res_data  <= w_sum;
            r_res_id    <= w_grant_idx;
            r_rr_ptr    <= w_ptr_next;
        end else if (w_res_hs) begin
            r_res_valid <= 1'b0;
        end
    end

    // Count delivered results; a result discarded by reset is never counted.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op_count <= '0;
        end else if (w_res_hs) begin
            r_op_count <= r_op_count + 16'd1;
        end
    end

    assign res_valid = r_res_valid;
    assign res_data  = r_res_data;
    assign res_id    = r_res_id;
    assign op_count  = r_op_count;
    assign idle      = (req_valid == '0) & ~r_res_valid;

endmodule

// File: doc/adder_rr_scheduler.md
ADDER_RR_SCHEDULER -- requirements
Module: adder_rr_scheduler

Interface
REQ-001 Parameter: NUM_REQ, 4, number of requesters sharing one 32-bit adder.
REQ-002 Parameter: DATA_W, 32, operand and result width.
REQ-003 The block SHALL use one clock; reset is synchronous and active-high.
REQ-004 Port: clk  input  1  rising-edge clock.
REQ-005 Port: rst  input  1  synchronous active-high reset.
REQ-006 Port: enable  input  1  1 = new grants allowed; 0 = no new grants, a pending result still drains.
REQ-007 Port: req_valid  input  NUM_REQ  per-requester operand valid.
REQ-008 Port: req_a  input  NUM_REQ*DATA_W  packed operand A; requester i at bits [i*DATA_W +: DATA_W].
REQ-009 Port: req_b  input  NUM_REQ*DATA_W  packed operand B; same packing as req_a.
REQ-010 Port: req_ready  output  NUM_REQ  one-hot grant; combinational; zero or one bit set.
REQ-011 Port: res_valid  output  1  result register holds an undelivered sum.
REQ-012 Port: res_ready  input  1  consumer accepts the result.
REQ-013 Port: res_data  output  DATA_W  registered sum.
REQ-014 Port: res_id  output  clog2(NUM_REQ)  index of the requester that produced res_data.
REQ-015 Port: op_count  output  16  count of completed result handshakes; wraps 0xFFFF -> 0x0000.
REQ-016 Port: idle  output  1  high when req_valid == 0 and res_valid == 0.

Function
REQ-017 The slot is free when res_valid == 0 or res_ready == 1 in the same cycle.
REQ-018 A grant SHALL occur only when enable == 1, the slot is free, and req_valid != 0.
REQ-019 The arbiter SHALL grant the first requester with req_valid set, searching from rr_ptr upward and wrapping from NUM_REQ-1 to 0.
REQ-020 On a grant to index g, rr_ptr SHALL become (g+1) mod NUM_REQ; with no grant, rr_ptr holds.
REQ-021 A request transfers when req_valid[i] & req_ready[i]; req_ready SHALL be all-zero whenever no grant occurs.
REQ-022 On a transfer, on the next edge: res_data = (req_a[g] + req_b[g]) mod 2^DATA_W, with carry-out discarded; res_id = g; res_valid = 1.
REQ-023 Latency SHALL be one cycle from transfer to res_valid.
REQ-024 Throughput SHALL be one operation per cycle while res_ready stays high.
REQ-025 When res_valid & res_ready and there is no grant, res_valid SHALL clear on the next edge.
REQ-026 While res_valid & !res_ready, res_data and res_id SHALL hold stable, and no grant occurs.
REQ-027 If a result drains and a new grant occurs in the same cycle, the new result SHALL replace the old one with no bubble.
REQ-028 Each res_valid & res_ready cycle SHALL increment op_count by 1.
REQ-029 When enable deasserts, any result already registered SHALL still complete its handshake.
REQ-030 A requester that has not been granted SHALL be allowed to change its operands freely.

Reset
REQ-031 While rst is high at a clock edge: res_valid = 0, res_data = 0, res_id = 0, rr_ptr = 0, op_count = 0.
REQ-032 req_ready SHALL be all-zero during any cycle in which rst is high.
REQ-033 A reset asserted mid-operation SHALL discard the pending result without a handshake and without incrementing op_count.

Structure
REQ-034 Package adder_sched_pkg SHALL hold: NUM_REQ, DATA_W, ID_W = clog2(NUM_REQ), and typedefs req_id_t and data_t.
REQ-035 The block SHALL instantiate exactly one fh_without_carry_adder_32_bits as the shared datapath.
REQ-036 The adder input SHALL be fed through a grant-indexed operand mux.
REQ-037 The round-robin arbiter SHALL stay inline; no other sub-module is required.

Verification
REQ-038 Scenario: after reset, req_valid = 4'b1111 with res_ready = 1 held -> grants in order 0,1,2,3,0; res_id follows the same order one cycle later; op_count = 5 after 5 results.
REQ-039 Scenario: requester 2 sends a = 0xFFFF_FFFF, b = 0x0000_0002 -> res_data = 0x0000_0001, res_id = 2.
REQ-040 Scenario: res_ready = 0 for 3 cycles while req_valid = 4'b0011 -> req_ready = 0 throughout and res_data stable; on release, back-to-back results with no bubble.
REQ-041 Scenario: enable = 0 with req_valid = 4'b0100 and one result pending -> pending result delivered, no new grant, idle stays 0.
REQ-042 Scenario: rst pulsed while res_valid = 1 -> next cycle res_valid = 0, op_count unchanged at 0, rr_ptr = 0.
REQ-043 Scenario: op_count preloaded by 65535 handshakes, then one more -> op_count = 0x0000.
